// File: rtl/intl_multi_ch.sv
// N-channel interlock core: polarity, 2-flop sync, debounce, bypass, fault latch, first-fault capture, trip count.
// Latency: raw pin edge at clock edge 0 -> o_intl_filt at edge 3+T -> o_intl_state/o_trip at edge 4+T.
// Backpressure: none; level-sensitive pins and clear are sampled every cycle, all outputs registered.
module intl_multi_ch #(
    parameter  int N_CH  = 8,
    parameter  int DEB_W = 16,
    parameter  int TS_W  = 32,
    parameter  int CNT_W = 16,
    localparam int IDX_W = $clog2(N_CH)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [N_CH-1:0]   i_intl_raw,
    input  logic [N_CH-1:0]   i_active_high,
    input  logic [N_CH-1:0]   i_bypass,
    input  logic [DEB_W-1:0]  i_deb_th,
    input  logic              i_intl_rst,
    output logic [N_CH-1:0]   o_intl_state,
    output logic [N_CH-1:0]   o_intl_filt,
    output logic              o_trip,
    output logic              o_first_valid,
    output logic [IDX_W-1:0]  o_first_ch,
    output logic [TS_W-1:0]   o_first_time,
    output logic [CNT_W-1:0]  o_trip_cnt
);

    typedef enum logic {
        ARMED   = 1'b0,
        TRIPPED = 1'b1
    } fsm_t;

    // Pin level normalised so that 1 always means "fault asserted".
    logic [N_CH-1:0]  asserted;

    // Two-flop synchroniser; sync_q2 is the clean per-channel level s.
    logic [N_CH-1:0]  sync_q1;
    logic [N_CH-1:0]  sync_q2;

    // Debounce state: filtered level f and per-channel run-length counter c.
    logic [N_CH-1:0]  filt;
    logic [DEB_W-1:0] deb_cnt [N_CH];

    // Fault latch and its next value.
    logic [N_CH-1:0]  state;
    logic [N_CH-1:0]  set_vec;
    logic [N_CH-1:0]  clr_vec;
    logic [N_CH-1:0]  state_nxt;
    logic [N_CH-1:0]  new_set;
    logic [IDX_W-1:0] first_idx;

    // Free-running timestamp and first-fault capture.
    fsm_t             fsm;
    logic [TS_W-1:0]  ts;
    logic             first_vld;
    logic [IDX_W-1:0] first_ch;
    logic [TS_W-1:0]  first_time;
    logic [CNT_W-1:0] trip_cnt;
    logic             trip;

    // XNOR with the polarity select: pin == active level means fault.
    assign asserted = i_intl_raw ~^ i_active_high;

    // Two-stage synchroniser for the asynchronous pins.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= asserted;
            sync_q2 <= sync_q1;
        end
    end

    // Debounce: f only follows s after s has differed from f for T+1 consecutive cycles.
    // The >= compare lets a threshold lowered below a running count take effect at once.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            filt <= '0;
            for (int i = 0; i < N_CH; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (sync_q2[i] == filt[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] >= i_deb_th) begin
                    filt[i]    <= sync_q2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
                end
            end
        end
    end

    // Next latch vector: set from unbypassed filtered faults, clear only channels no longer asserted.
    // Set and clear both key off the same f, so a channel is never set and cleared together.
    always_comb begin
        set_vec   = filt & ~i_bypass;
        clr_vec   = i_intl_rst ? ~filt : '0;
        state_nxt = set_vec | (state & ~clr_vec);
        new_set   = state_nxt & ~state;
    end

    // Lowest-index channel among those newly latching this cycle.
    always_comb begin
        first_idx = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (new_set[i]) begin
                first_idx = IDX_W'(i);
            end
        end
    end

    // Trip FSM with latch vector, timestamp, first-fault capture and saturating trip counter.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            fsm        <= ARMED;
            state      <= '0;
            trip       <= 1'b0;
            ts         <= '0;
            first_vld  <= 1'b0;
            first_ch   <= '0;
            first_time <= '0;
            trip_cnt   <= '0;
        end else begin
            ts    <= ts + TS_W'(1);
            state <= state_nxt;
            trip  <= |state_nxt;
            case (fsm)
                ARMED: begin
                    if (|state_nxt) begin
                        fsm        <= TRIPPED;
                        first_vld  <= 1'b1;
                        first_ch   <= first_idx;
                        first_time <= ts;
                        if (trip_cnt != '1) begin
                            trip_cnt <= trip_cnt + CNT_W'(1);
                        end
                    end
                end
                TRIPPED: begin
                    // Only a clear can empty the latch vector; first-fault data stays frozen until then.
                    if (!(|state_nxt)) begin
                        fsm        <= ARMED;
                        first_vld  <= 1'b0;
                        first_ch   <= '0;
                        first_time <= '0;
                    end
                end
            endcase
        end
    end

    assign o_intl_state  = state;
    assign o_intl_filt   = filt;
    assign o_trip        = trip;
    assign o_first_valid = first_vld;
    assign o_first_ch    = first_ch;
    assign o_first_time  = first_time;
    assign o_trip_cnt    = trip_cnt;

endmodule

// File: tb/tb_intl_multi_ch.sv
// Bench for intl_multi_ch: default-size instance plus a small instance for counter saturation and timestamp wrap.
// Expected values are queued with the clock edge they are due at and compared on the following falling edge.
// No flow control; stimulus is a fixed cycle schedule.
module tb_intl_multi_ch;

    localparam int SG_STATE  = 0;
    localparam int SG_FILT   = 1;
    localparam int SG_TRIP   = 2;
    localparam int SG_FVLD   = 3;
    localparam int SG_FCH    = 4;
    localparam int SG_FTIME  = 5;
    localparam int SG_TCNT   = 6;
    localparam int SG2_STATE = 7;
    localparam int SG2_FVLD  = 8;
    localparam int SG2_FCH   = 9;
    localparam int SG2_FTIME = 10;
    localparam int SG2_TCNT  = 11;
    localparam int SG2_TRIP  = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance, default parameters.
    logic        rst;
    logic [7:0]  raw, ah, byp;
    logic [15:0] th;
    logic        clr;
    logic [7:0]  st, filt;
    logic        trip, fvld;
    logic [2:0]  fch;
    logic [31:0] ftime;
    logic [15:0] tcnt;

    // Small instance: 4 channels, 2-bit trip counter, 4-bit timestamp.
    logic        rst2;
    logic [3:0]  raw2, ah2, byp2;
    logic [15:0] th2;
    logic        clr2;
    logic [3:0]  st2, filt2;
    logic        trip2, fvld2;
    logic [1:0]  fch2;
    logic [3:0]  ftime2;
    logic [1:0]  tcnt2;

    intl_multi_ch dut (
        .i_clk(clk), .i_rst(rst), .i_intl_raw(raw), .i_active_high(ah), .i_bypass(byp),
        .i_deb_th(th), .i_intl_rst(clr), .o_intl_state(st), .o_intl_filt(filt), .o_trip(trip),
        .o_first_valid(fvld), .o_first_ch(fch), .o_first_time(ftime), .o_trip_cnt(tcnt)
    );

    intl_multi_ch #(.N_CH(4), .DEB_W(16), .TS_W(4), .CNT_W(2)) dut2 (
        .i_clk(clk), .i_rst(rst2), .i_intl_raw(raw2), .i_active_high(ah2), .i_bypass(byp2),
        .i_deb_th(th2), .i_intl_rst(clr2), .o_intl_state(st2), .o_intl_filt(filt2), .o_trip(trip2),
        .o_first_valid(fvld2), .o_first_ch(fch2), .o_first_time(ftime2), .o_trip_cnt(tcnt2)
    );

    typedef struct {
        string       tag;
        int          due;
        int          sig;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   cyc     = 0;
    int   n_chk   = 0;
    int   n_err   = 0;
    int   rel     = 0;
    int   rel2    = 0;
    int   exp_cnt = 0;
    int   tfirst  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (edge %0d)", tag, got, want, cyc);
        end
    endtask

    function automatic logic [31:0] obs(input int sig);
        case (sig)
            SG_STATE:  obs = 32'(st);
            SG_FILT:   obs = 32'(filt);
            SG_TRIP:   obs = 32'(trip);
            SG_FVLD:   obs = 32'(fvld);
            SG_FCH:    obs = 32'(fch);
            SG_FTIME:  obs = ftime;
            SG_TCNT:   obs = 32'(tcnt);
            SG2_STATE: obs = 32'(st2);
            SG2_FVLD:  obs = 32'(fvld2);
            SG2_FCH:   obs = 32'(fch2);
            SG2_FTIME: obs = 32'(ftime2);
            SG2_TCNT:  obs = 32'(tcnt2);
            SG2_TRIP:  obs = 32'(trip2);
            default:   obs = 'x;
        endcase
    endfunction

    // Scoreboard drain: every entry due at the edge just taken is compared, then removed.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                chk(sb[i].tag, obs(sb[i].sig), sb[i].val);
                sb.delete(i);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_at(input string tag, input int due, input int sig, input logic [31:0] v);
        exp_t e;
        if (due < cyc) begin
            n_err++;
            $display("FAIL %s: expectation queued for past edge %0d at edge %0d", tag, due, cyc);
        end else begin
            e.tag = tag;
            e.due = due;
            e.sig = sig;
            e.val = v;
            sb.push_back(e);
        end
    endtask

    // Trip on the main instance: first-fault time is the timestamp value in the cycle before the latching edge.
    task automatic expect_trip(input string tag, input int due, input logic [31:0] stv,
                               input logic [31:0] ch, input int cnt);
        expect_at({tag, "_state"}, due, SG_STATE, stv);
        expect_at({tag, "_trip"},  due, SG_TRIP,  32'd1);
        expect_at({tag, "_fvld"},  due, SG_FVLD,  32'd1);
        expect_at({tag, "_fch"},   due, SG_FCH,   ch);
        expect_at({tag, "_ftime"}, due, SG_FTIME, 32'(due - rel - 1));
        expect_at({tag, "_tcnt"},  due, SG_TCNT,  32'(cnt));
    endtask

    // One-cycle clear with every channel already deasserted: back to ARMED, counter kept.
    task automatic clear_pulse(input string tag);
        clr = 1'b1;
        expect_at({tag, "_state"}, cyc + 1, SG_STATE, 32'd0);
        expect_at({tag, "_trip"},  cyc + 1, SG_TRIP,  32'd0);
        expect_at({tag, "_fvld"},  cyc + 1, SG_FVLD,  32'd0);
        expect_at({tag, "_fch"},   cyc + 1, SG_FCH,   32'd0);
        expect_at({tag, "_ftime"}, cyc + 1, SG_FTIME, 32'd0);
        expect_at({tag, "_tcnt"},  cyc + 1, SG_TCNT,  32'(exp_cnt));
        tick(1);
        clr = 1'b0;
    endtask

    initial begin
        int r, e, f, g, h, q, s, u, v, w, x, y;
        rst  = 1'b0; raw  = 8'hFF; ah  = 8'hFF; byp  = 8'h00; th  = 16'd3; clr  = 1'b0;
        rst2 = 1'b0; raw2 = 4'h0;  ah2 = 4'hF;  byp2 = 4'h0;  th2 = 16'd0; clr2 = 1'b0;

        // Reset with every pin at its fault level: outputs must stay 0.
        tick(2);
        expect_at("rst_state", cyc, SG_STATE, 0);
        expect_at("rst_filt",  cyc, SG_FILT,  0);
        expect_at("rst_trip",  cyc, SG_TRIP,  0);
        expect_at("rst_fvld",  cyc, SG_FVLD,  0);
        expect_at("rst_ftime", cyc, SG_FTIME, 0);
        expect_at("rst_tcnt",  cyc, SG_TCNT,  0);
        expect_at("rst2_state", cyc, SG2_STATE, 0);
        tick(3);
        expect_at("rst_state_end", cyc, SG_STATE, 0);

        // Release with T=3: filt at +6, latch at +7, first channel 0.
        r = cyc; rst = 1'b1; rel = r;
        expect_at("rel_filt_early", r + 5, SG_FILT, 32'h00);
        expect_at("rel_filt",       r + 6, SG_FILT, 32'hFF);
        expect_at("rel_state_early", r + 6, SG_STATE, 32'h00);
        exp_cnt++;
        expect_trip("rel", r + 7, 32'hFF, 0, exp_cnt);
        tick(8);
        e = cyc; raw = 8'h00;
        expect_at("rel_fall_early", e + 5, SG_FILT, 32'hFF);
        expect_at("rel_fall",       e + 6, SG_FILT, 32'h00);
        tick(8);
        clear_pulse("clr0");

        // Debounce, T=10: 10-cycle pulse rejected, 11-cycle pulse accepted.
        th = 16'd10;
        tick(2);
        q = cyc; raw[2] = 1'b1;
        expect_at("p10_filt",  q + 13, SG_FILT,  0);
        expect_at("p10_state", q + 14, SG_STATE, 0);
        expect_at("p10_trip",  q + 14, SG_TRIP,  0);
        tick(10);
        raw[2] = 1'b0;
        tick(6);
        q = cyc; raw[2] = 1'b1;
        expect_at("p11_filt_early", q + 12, SG_FILT, 32'h00);
        expect_at("p11_filt",       q + 13, SG_FILT, 32'h04);
        expect_at("p11_state_early", q + 13, SG_STATE, 32'h00);
        exp_cnt++;
        expect_trip("p11", q + 14, 32'h04, 2, exp_cnt);
        expect_at("p11_fall_early", q + 23, SG_FILT, 32'h04);
        expect_at("p11_fall",       q + 24, SG_FILT, 32'h00);
        tick(11);
        raw[2] = 1'b0;
        tick(16);
        clear_pulse("clr1");

        // Polarity: ch5 active-low, pin driven low means fault.
        th = 16'd0;
        raw[5] = 1'b1; ah[5] = 1'b0;
        tick(3);
        f = cyc; raw[5] = 1'b0;
        expect_at("pol_filt", f + 3, SG_FILT, 32'h20);
        expect_at("pol_state_early", f + 3, SG_STATE, 32'h00);
        exp_cnt++;
        expect_trip("pol", f + 4, 32'h20, 5, exp_cnt);
        tick(6);
        g = cyc; byp[5] = 1'b1;
        expect_at("byp_after_state", g + 2, SG_STATE, 32'h20);
        expect_at("byp_after_trip",  g + 2, SG_TRIP,  32'd1);
        tick(2);
        raw[5] = 1'b1;
        tick(5);
        clear_pulse("clr2");
        // Bypassed channel: filtered level visible, no latch.
        tick(1);
        h = cyc; raw[5] = 1'b0;
        expect_at("byp_filt",   h + 3, SG_FILT,  32'h20);
        expect_at("byp_state",  h + 4, SG_STATE, 32'h00);
        expect_at("byp_trip",   h + 4, SG_TRIP,  32'd0);
        expect_at("byp_state2", h + 6, SG_STATE, 32'h00);
        expect_at("byp_fvld",   h + 6, SG_FVLD,  32'd0);
        tick(6);
        raw[5] = 1'b1;
        tick(5);
        byp = 8'h00; ah[5] = 1'b1; raw[5] = 1'b0;
        expect_at("restore_filt",  cyc + 3, SG_FILT,  32'h00);
        expect_at("restore_state", cyc + 4, SG_STATE, 32'h00);
        tick(5);

        // Simultaneous ch6+ch3, later ch1: first channel stays 3.
        tick(1);
        s = cyc; raw = 8'h48;
        expect_at("sim_filt", s + 3, SG_FILT, 32'h48);
        exp_cnt++;
        expect_trip("sim", s + 4, 32'h48, 3, exp_cnt);
        tfirst = s + 4 - rel - 1;
        tick(6);
        raw = 8'h4A;
        expect_at("late_state", s + 10, SG_STATE, 32'h4A);
        expect_at("late_fch",   s + 10, SG_FCH,   32'd3);
        expect_at("late_ftime", s + 10, SG_FTIME, 32'(tfirst));
        expect_at("late_tcnt",  s + 10, SG_TCNT,  32'(exp_cnt));
        expect_at("late_fvld",  s + 10, SG_FVLD,  32'd1);
        tick(6);

        // Partial clear: ch3 still asserted keeps TRIPPED and first-fault data.
        u = cyc; raw = 8'h08;
        tick(5);
        v = cyc; clr = 1'b1;
        expect_at("pclr_state", v + 1, SG_STATE, 32'h08);
        expect_at("pclr_trip",  v + 1, SG_TRIP,  32'd1);
        expect_at("pclr_fvld",  v + 1, SG_FVLD,  32'd1);
        expect_at("pclr_fch",   v + 1, SG_FCH,   32'd3);
        expect_at("pclr_ftime", v + 1, SG_FTIME, 32'(tfirst));
        tick(1);
        clr = 1'b0;
        tick(2);
        w = cyc; raw = 8'h00;
        tick(5);
        clear_pulse("clr3");

        // Clear held while ARMED: no effect, a new fault still latches, then clears when it drops.
        tick(1);
        clr = 1'b1;
        expect_at("hold_idle_state", cyc + 2, SG_STATE, 32'h00);
        expect_at("hold_idle_trip",  cyc + 2, SG_TRIP,  32'd0);
        tick(3);
        x = cyc; raw = 8'h80;
        exp_cnt++;
        expect_trip("hold", x + 4, 32'h80, 7, exp_cnt);
        tick(6);
        y = cyc; raw = 8'h00;
        expect_at("hold_fall_state_early", y + 3, SG_STATE, 32'h80);
        expect_at("hold_fall_state", y + 4, SG_STATE, 32'h00);
        expect_at("hold_fall_trip",  y + 4, SG_TRIP,  32'd0);
        expect_at("hold_fall_fvld",  y + 4, SG_FVLD,  32'd0);
        expect_at("hold_fall_ftime", y + 4, SG_FTIME, 32'd0);
        tick(6);
        clr = 1'b0;

        // Small instance: fault latching 21 edges after release -> timestamp 20 mod 16 = 4.
        tick(1);
        rel2 = cyc; rst2 = 1'b1;
        tick(17);
        e = cyc; raw2 = 4'b0010;
        expect_at("wrap_state", e + 4, SG2_STATE, 32'h2);
        expect_at("wrap_ftime", e + 4, SG2_FTIME, 32'd4);
        expect_at("wrap_fch",   e + 4, SG2_FCH,   32'd1);
        expect_at("wrap_tcnt",  e + 4, SG2_TCNT,  32'd1);
        expect_at("wrap_trip",  e + 4, SG2_TRIP,  32'd1);
        tick(6);
        // Four more trip/clear cycles: counter saturates at 3.
        for (int k = 2; k <= 5; k++) begin
            raw2 = 4'h0;
            tick(5);
            clr2 = 1'b1;
            expect_at($sformatf("sat%0d_clr_state", k), cyc + 1, SG2_STATE, 32'h0);
            expect_at($sformatf("sat%0d_clr_fvld", k),  cyc + 1, SG2_FVLD,  32'd0);
            tick(1);
            clr2 = 1'b0;
            tick(1);
            raw2 = 4'(1 << (k % 4));
            expect_at($sformatf("sat%0d_state", k), cyc + 4, SG2_STATE, 32'(raw2));
            expect_at($sformatf("sat%0d_fch", k),   cyc + 4, SG2_FCH,   32'(k % 4));
            expect_at($sformatf("sat%0d_tcnt", k),  cyc + 4, SG2_TCNT,  32'((k > 3) ? 3 : k));
            tick(6);
        end

        // Drain anything still pending; leftovers are failures.
        for (int i = 0; i < 20 && sb.size() != 0; i++) tick(1);
        foreach (sb[i]) begin
            n_err++;
            $display("FAIL %s: expectation for edge %0d never evaluated (now %0d)", sb[i].tag, sb[i].due, cyc);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
